// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and fetch-state encoding for the MIPS pipeline.
package mips_pkg;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] MIPS_NOP_INSTR = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/if_pc_gen.sv
// if_pc_gen: program counter register with redirect / +4 / hold next-PC select.
module if_pc_gen
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            advance,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4
);
    logic [PC_W-1:0] pc_next;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = redirect ? {redirect_pc[PC_W-1:2], 2'b00} : advance ? pc_plus4 : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_next;
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage (PC, imem handshake, IF/ID register).
// Define IF_DELAY_SLOT_EN to keep IF/ID across a redirect (branch delay slot).
module if_stage
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [PC_W-1:0] NOP_INSTR = MIPS_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] o_IF_imem_Addr,
    output logic            o_IF_imem_Req,
    input  logic            i_IF_imem_Ready,
    input  logic [PC_W-1:0] i_IF_imem_Data,
    input  logic            i_IF_ctrl_Stall,
    input  logic            i_IF_ctrl_Redirect,
    input  logic [PC_W-1:0] i_IF_data_RedirectPC,
    output logic [PC_W-1:0] o_ID_data_instruction,
    output logic            o_ID_data_Valid,
    output logic [PC_W-1:0] o_EX_data_PCNext
);
    fetch_state_t state, state_next;
    logic [PC_W-1:0] pc, pc_plus4;
    logic take;

    // Redirect and stall both discard any data returned this cycle
    assign take = o_IF_imem_Req && i_IF_imem_Ready && !i_IF_ctrl_Stall && !i_IF_ctrl_Redirect;
    assign o_IF_imem_Addr = pc;

    if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .redirect    (i_IF_ctrl_Redirect),
        .redirect_pc (i_IF_data_RedirectPC),
        .advance     (take),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = i_IF_ctrl_Redirect ? S_FETCH :
                     state == S_BOOT    ? S_FETCH :
                     state == S_HOLD    ? (i_IF_ctrl_Stall ? S_HOLD : S_FETCH) :
                     i_IF_ctrl_Stall    ? S_HOLD :
                     i_IF_imem_Ready    ? S_FETCH : S_WAIT;
    end

    always_comb begin
        o_IF_imem_Req = (state == S_FETCH) || (state == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_ID_data_instruction <= NOP_INSTR;
            o_ID_data_Valid       <= 1'b0;
            o_EX_data_PCNext      <= '0;
`ifndef IF_DELAY_SLOT_EN
        end else if (i_IF_ctrl_Redirect) begin
            o_ID_data_instruction <= NOP_INSTR;
            o_ID_data_Valid       <= 1'b0;
            o_EX_data_PCNext      <= '0;
`endif
        end else if (take) begin
            o_ID_data_instruction <= i_IF_imem_Data;
            o_ID_data_Valid       <= 1'b1;
            o_EX_data_PCNext      <= pc_plus4;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + random stimulus against a behavioural fetch model.
// Honours IF_DELAY_SLOT_EN the same way the design does.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] o_IF_imem_Addr;
    logic        o_IF_imem_Req;
    logic        i_IF_imem_Ready;
    logic [31:0] i_IF_imem_Data;
    logic        i_IF_ctrl_Stall;
    logic        i_IF_ctrl_Redirect;
    logic [31:0] i_IF_data_RedirectPC;
    logic [31:0] o_ID_data_instruction;
    logic        o_ID_data_Valid;
    logic [31:0] o_EX_data_PCNext;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] m_pc, m_instr, m_pcnext;
    logic        m_valid, m_boot, m_hold;

    if_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .o_IF_imem_Addr        (o_IF_imem_Addr),
        .o_IF_imem_Req         (o_IF_imem_Req),
        .i_IF_imem_Ready       (i_IF_imem_Ready),
        .i_IF_imem_Data        (i_IF_imem_Data),
        .i_IF_ctrl_Stall       (i_IF_ctrl_Stall),
        .i_IF_ctrl_Redirect    (i_IF_ctrl_Redirect),
        .i_IF_data_RedirectPC  (i_IF_data_RedirectPC),
        .o_ID_data_instruction (o_ID_data_instruction),
        .o_ID_data_Valid       (o_ID_data_Valid),
        .o_EX_data_PCNext      (o_EX_data_PCNext)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic cyc(input logic r, input logic rdy, input logic stl, input logic rd,
                       input logic [31:0] rpc);
        logic [31:0] d;
        d = $urandom;
        rst = r;
        i_IF_imem_Ready = rdy;
        i_IF_ctrl_Stall = stl;
        i_IF_ctrl_Redirect = rd;
        i_IF_data_RedirectPC = rpc;
        i_IF_imem_Data = d;
        if (r) begin
            m_pc = 32'h0; m_boot = 1; m_hold = 0;
            m_instr = 32'h0; m_valid = 0; m_pcnext = 32'h0;
        end else if (rd) begin
            m_pc = rpc & 32'hFFFF_FFFC; m_boot = 0; m_hold = 0;
`ifndef IF_DELAY_SLOT_EN
            m_instr = 32'h0; m_valid = 0; m_pcnext = 32'h0;
`endif
        end else if (m_boot) m_boot = 0;
        else if (m_hold) m_hold = stl;
        else if (stl) m_hold = 1;
        else if (rdy) begin
            m_instr = d; m_valid = 1; m_pcnext = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        chk("addr", o_IF_imem_Addr, m_pc);
        chk("req", {31'b0, o_IF_imem_Req}, {31'b0, !m_boot && !m_hold});
        chk("instr", o_ID_data_instruction, m_instr);
        chk("valid", {31'b0, o_ID_data_Valid}, {31'b0, m_valid});
        chk("pcnext", o_EX_data_PCNext, m_pcnext);
    endtask

    initial begin
        logic [31:0] held;
        rst = 1; i_IF_imem_Ready = 0; i_IF_imem_Data = 0;
        i_IF_ctrl_Stall = 0; i_IF_ctrl_Redirect = 0; i_IF_data_RedirectPC = 0;
        cyc(1, 0, 0, 0, 0);
        chk("rst_req", {31'b0, o_IF_imem_Req}, 32'd0);
        chk("rst_addr", o_IF_imem_Addr, 32'd0);
        cyc(0, 1, 0, 0, 0);
        chk("boot_to_fetch_req", {31'b0, o_IF_imem_Req}, 32'd1);
        cyc(0, 1, 0, 0, 0);
        chk("first_pcnext", o_EX_data_PCNext, 32'd4);
        chk("first_valid", {31'b0, o_ID_data_Valid}, 32'd1);
        cyc(0, 1, 0, 0, 0);
        chk("second_pcnext", o_EX_data_PCNext, 32'd8);
        // Memory not ready at PC=8
        held = o_ID_data_instruction;
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("wait_addr", o_IF_imem_Addr, 32'd8);
        chk("wait_instr_held", o_ID_data_instruction, held);
        cyc(0, 1, 0, 0, 0);
        chk("after_wait_addr", o_IF_imem_Addr, 32'd12);
        cyc(0, 1, 0, 0, 0);
        // Stall at PC=16
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("hold_req", {31'b0, o_IF_imem_Req}, 32'd0);
        chk("hold_addr", o_IF_imem_Addr, 32'd16);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("resume_pcnext", o_EX_data_PCNext, 32'd20);
        // Redirect while stalled, misaligned target
        cyc(0, 1, 1, 1, 32'h0000_0043);
        chk("redir_addr", o_IF_imem_Addr, 32'h40);
`ifndef IF_DELAY_SLOT_EN
        chk("redir_flush_valid", {31'b0, o_ID_data_Valid}, 32'd0);
`else
        chk("redir_ds_pcnext", o_EX_data_PCNext, 32'd20);
`endif
        // PC wrap
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 0, 0);
        chk("wrap_pcnext", o_EX_data_PCNext, 32'd0);
        chk("wrap_addr", o_IF_imem_Addr, 32'd0);
        // Reset during wait at PC=20
        cyc(0, 0, 0, 1, 32'd20);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("rst_wait_addr", o_IF_imem_Addr, 32'd0);
        chk("rst_wait_valid", {31'b0, o_ID_data_Valid}, 32'd0);
        repeat (3000) cyc(($urandom % 64) == 0, ($urandom % 10) < 7, ($urandom % 5) == 0,
                          ($urandom % 8) == 0, $urandom);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
